// File: rtl/vga_scanout.sv
// Read side of the line-doubled frame buffer. It generates the 800x600@60 raster,
// fetches 1-bit pixels from the frame RAM read port and drives the VGA connector.
module vga_scanout #(
    parameter int         H_VIS     = 800,
    parameter int         H_FP      = 40,
    parameter int         H_SYNC    = 128,
    parameter int         H_BP      = 88,
    parameter int         V_VIS     = 600,
    parameter int         V_FP      = 1,
    parameter int         V_SYNC    = 4,
    parameter int         V_BP      = 23,
    parameter int         SRC_LINES = 240,
    parameter int         V_OFFSET  = 60,
    parameter int         RD_LAT    = 1,
    parameter logic [2:0] FG_RGB    = 3'b010
) (
    input  logic        vgaclk,
    input  logic        reset,
    output logic [17:0] raddr,
    input  logic        rdata,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        vga_r,
    output logic        vga_g,
    output logic        vga_b,
    output logic        frame_start
);

    localparam int H_TOT   = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT   = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOT);
    localparam int VW      = $clog2(V_TOT);
    localparam int HS_BEG  = H_VIS + H_FP;
    localparam int HS_END  = HS_BEG + H_SYNC - 1;
    localparam int VS_BEG  = V_VIS + V_FP;
    localparam int VS_END  = VS_BEG + V_SYNC - 1;
    localparam int IMG_BEG = V_OFFSET;
    localparam int IMG_END = V_OFFSET + 2 * SRC_LINES - 1;
    localparam logic OFF_ODD = (V_OFFSET % 2) != 0;

    logic [HW-1:0] hcnt_reg;
    logic [HW-1:0] hcnt_next;
    logic [VW-1:0] vcnt_reg;
    logic [VW-1:0] vcnt_next;
    logic [17:0]   linebase_reg;
    logic [17:0]   linebase_next;
    logic          armed_reg;
    logic          armed_next;
    logic [17:0]   raddr_reg;
    logic          h_wrap;
    logic          v_wrap;
    logic          second_of_pair;
    logic          img_next;

    logic          hs0;
    logic          vs0;
    logic          act0;
    logic          img0;
    logic          fs0;
    logic [3:0]    dec0;
    logic [3:0]    dec_d;

    logic          hsync_reg;
    logic          vsync_reg;
    logic [2:0]    rgb_reg;
    logic          frame_start_reg;

    // Next raster position and the line base that goes with it. The read address
    // is registered from these so that raddr lines up with the current counters.
    always_comb begin
        h_wrap         = (hcnt_reg == HW'(H_TOT - 1));
        v_wrap         = h_wrap && (vcnt_reg == VW'(V_TOT - 1));
        second_of_pair = vcnt_reg[0] ^ OFF_ODD;
        hcnt_next      = h_wrap ? '0 : hcnt_reg + 1'b1;
        vcnt_next      = vcnt_reg;
        if (h_wrap) begin
            vcnt_next = v_wrap ? '0 : vcnt_reg + 1'b1;
        end
        linebase_next = linebase_reg;
        if (v_wrap) begin
            linebase_next = '0;
        end else if (h_wrap && second_of_pair &&
                     vcnt_reg >= VW'(IMG_BEG) && vcnt_reg < VW'(IMG_END)) begin
            linebase_next = linebase_reg + 18'(H_VIS);
        end
        armed_next = armed_reg | v_wrap;
        img_next   = (hcnt_next < HW'(H_VIS)) &&
                     (vcnt_next >= VW'(IMG_BEG)) && (vcnt_next <= VW'(IMG_END));
    end

    // Decode of the current raster position.
    always_comb begin
        hs0  = (hcnt_reg >= HW'(HS_BEG)) && (hcnt_reg <= HW'(HS_END));
        vs0  = (vcnt_reg >= VW'(VS_BEG)) && (vcnt_reg <= VW'(VS_END));
        act0 = (hcnt_reg < HW'(H_VIS)) && (vcnt_reg < VW'(V_VIS));
        img0 = act0 && (vcnt_reg >= VW'(IMG_BEG)) && (vcnt_reg <= VW'(IMG_END));
        // The frame that reset interrupted is not announced; the first frame
        // reached by a natural wrap is.
        fs0  = armed_reg && (hcnt_reg == '0) && (vcnt_reg == '0);
        dec0 = {fs0, hs0, vs0, img0};
    end

    always_ff @(posedge vgaclk) begin
        if (reset) begin
            hcnt_reg     <= '0;
            vcnt_reg     <= '0;
            linebase_reg <= '0;
            armed_reg    <= 1'b0;
            raddr_reg    <= '0;
        end else begin
            hcnt_reg     <= hcnt_next;
            vcnt_reg     <= vcnt_next;
            linebase_reg <= linebase_next;
            armed_reg    <= armed_next;
            raddr_reg    <= img_next ? (linebase_next + 18'(hcnt_next)) : '0;
        end
    end

    // Decode delay line: RD_LAT stages so the flags meet rdata at the output register.
    generate
        for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_pipe
            logic [3:0] stage_reg;
            logic [3:0] stage_in;
            if (gi == 0) begin : g_head
                assign stage_in = dec0;
            end else begin : g_link
                assign stage_in = g_pipe[gi-1].stage_reg;
            end
            always_ff @(posedge vgaclk) begin
                if (reset) begin
                    stage_reg <= '0;
                end else begin
                    stage_reg <= stage_in;
                end
            end
        end
    endgenerate

    assign dec_d = g_pipe[RD_LAT-1].stage_reg;

    always_ff @(posedge vgaclk) begin
        if (reset) begin
            hsync_reg       <= 1'b0;
            vsync_reg       <= 1'b0;
            rgb_reg         <= 3'b000;
            frame_start_reg <= 1'b0;
        end else begin
            frame_start_reg <= dec_d[3];
            hsync_reg       <= dec_d[2];
            vsync_reg       <= dec_d[1];
            rgb_reg         <= (dec_d[0] && rdata) ? FG_RGB : 3'b000;
        end
    end

    assign raddr       = raddr_reg;
    assign vga_hsync   = hsync_reg;
    assign vga_vsync   = vsync_reg;
    assign vga_r       = rgb_reg[2];
    assign vga_g       = rgb_reg[1];
    assign vga_b       = rgb_reg[0];
    assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: two instances (read latency 1 and 2) on a reduced raster,
// compared cycle by cycle against an arithmetic model of the scan.
module tb_vga_scanout;

    localparam int HV = 40, HFP = 4, HSW = 8, HBP = 6;
    localparam int VV = 30, VFP = 1, VSW = 2, VBP = 3;
    localparam int SRC = 10, VOFF = 5;
    localparam int HT = HV + HFP + HSW + HBP;
    localparam int VT = VV + VFP + VSW + VBP;
    localparam int FRAME = HT * VT;
    localparam int DEPTH = SRC * HV;
    localparam logic [2:0] FG = 3'b010;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic mem [DEPTH];

    logic [17:0] raddr1, raddr2;
    logic rdata1, rd2a, rdata2;
    logic hs1, vs1, r1, g1, b1, fs1;
    logic hs2, vs2, r2, g2, b2, fs2;

    vga_scanout #(
        .H_VIS(HV), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_VIS(VV), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .SRC_LINES(SRC), .V_OFFSET(VOFF), .RD_LAT(1), .FG_RGB(FG)
    ) u_dut1 (
        .vgaclk(clk), .reset(reset), .raddr(raddr1), .rdata(rdata1),
        .vga_hsync(hs1), .vga_vsync(vs1), .vga_r(r1), .vga_g(g1), .vga_b(b1),
        .frame_start(fs1)
    );

    vga_scanout #(
        .H_VIS(HV), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_VIS(VV), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .SRC_LINES(SRC), .V_OFFSET(VOFF), .RD_LAT(2), .FG_RGB(FG)
    ) u_dut2 (
        .vgaclk(clk), .reset(reset), .raddr(raddr2), .rdata(rdata2),
        .vga_hsync(hs2), .vga_vsync(vs2), .vga_r(r2), .vga_g(g2), .vga_b(b2),
        .frame_start(fs2)
    );

    // RAM read ports of latency 1 and 2.
    always @(posedge clk) begin
        rdata1 <= (int'(raddr1) < DEPTH) ? mem[raddr1] : 1'b0;
        rd2a   <= (int'(raddr2) < DEPTH) ? mem[raddr2] : 1'b0;
        rdata2 <= rd2a;
    end

    int t = 0;
    bit rst_q = 1'b1;
    bit started = 1'b0;
    int n_cmp = 0;
    int n_err = 0;
    bit fs_pending [1:2];

    always @(posedge clk) begin
        started <= 1'b1;
        rst_q   <= reset;
        t       <= reset ? 0 : t + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit in_image(int h, int v);
        return (h < HV) && (v >= VOFF) && (v < VOFF + 2 * SRC);
    endfunction

    // Expected read address in cycle tc after reset release.
    function automatic logic [17:0] exp_addr(int tc);
        int h = tc % HT;
        int v = (tc / HT) % VT;
        if (in_image(h, v)) return 18'(((v - VOFF) / 2) * HV + h);
        return '0;
    endfunction

    // Expected {frame_start, hsync, vsync, r, g, b} in cycle tc for read latency lat.
    function automatic logic [5:0] exp_out(int tc, int lat);
        int tt = tc - lat - 1;
        int h, v;
        logic hs, vs, fs, pix;
        if (tt < 0) return '0;
        h   = tt % HT;
        v   = (tt / HT) % VT;
        hs  = (h >= HV + HFP) && (h < HV + HFP + HSW);
        vs  = (v >= VV + VFP) && (v < VV + VFP + VSW);
        fs  = (tt >= FRAME) && (tt % FRAME == 0);
        pix = 1'b0;
        if (in_image(h, v)) pix = mem[((v - VOFF) / 2) * HV + h];
        return {fs, hs, vs, pix ? FG : 3'b000};
    endfunction

    task automatic check_dut(input int id, input int lat, input logic [17:0] ra,
                             input logic [5:0] o);
        if (rst_q) begin
            check($sformatf("dut%0d reset_raddr t=%0d", id, t), 32'(ra), 32'd0);
            check($sformatf("dut%0d reset_out t=%0d", id, t), 32'(o), 32'd0);
            fs_pending[id] = 1'b1;
        end else begin
            check($sformatf("dut%0d raddr t=%0d", id, t), 32'(ra), 32'(exp_addr(t)));
            check($sformatf("dut%0d out t=%0d", id, t), 32'(o), 32'(exp_out(t, lat)));
            if (o[5]) begin
                $display("dut%0d frame_start at cycle %0d after release", id, t);
                if (fs_pending[id]) begin
                    check($sformatf("dut%0d first_fs_cycle", id), t, FRAME + lat + 1);
                    fs_pending[id] = 1'b0;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            check_dut(1, 1, raddr1, {fs1, hs1, vs1, r1, g1, b1});
            check_dut(2, 2, raddr2, {fs2, hs2, vs2, r2, g2, b2});
        end
    end

    // Assert reset for five cycles; the RAM image is swapped while reset is held.
    task automatic pulse_reset(input int pattern);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < DEPTH; i++) begin
            case (pattern)
                0:       mem[i] = 1'b0;
                1:       mem[i] = 1'b1;
                default: mem[i] = 1'($urandom_range(1, 0));
            endcase
        end
        if (pattern == 0) begin
            mem[5] = 1'b1;
            mem[(SRC - 1) * HV + HV - 1] = 1'b1;
        end
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        $display("reset released, ram pattern %0d", pattern);
    endtask

    task automatic run_to(input int offset);
        for (int k = 0; k < FRAME && (t % FRAME) != offset; k++) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
    endtask

    task automatic phase_end(input string name);
        check($sformatf("%s dut1 fs_seen", name), 32'(fs_pending[1]), 32'd0);
        check($sformatf("%s dut2 fs_seen", name), 32'(fs_pending[2]), 32'd0);
    endtask

    initial begin
        fs_pending[1] = 1'b1;
        fs_pending[2] = 1'b1;
        @(negedge clk);
        // Two isolated pixels at the first and last source lines.
        pulse_reset(0);
        repeat (2 * FRAME + 40) @(posedge clk);
        phase_end("pixels");
        // Reset mid-line in the middle of the frame; rdata effectively stuck at 1.
        run_to((VV / 2) * HT + HV / 2);
        pulse_reset(1);
        repeat (FRAME + 60) @(posedge clk);
        phase_end("ones");
        // Reset inside an hsync pulse on a random line; random picture.
        run_to($urandom_range(VT - 1, 0) * HT + HV + HFP + $urandom_range(HSW - 1, 0));
        pulse_reset(2);
        repeat (2 * FRAME + 40) @(posedge clk);
        phase_end("random");
        // Reset inside the vsync pulse; random picture again.
        run_to((VV + VFP) * HT + $urandom_range(HT - 1, 0));
        pulse_reset(2);
        repeat (FRAME + 60) @(posedge clk);
        phase_end("vsync");
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
